// File: rtl/vbsme_pkg.sv
// Shared types and helpers for the VBSME SAD search path.
package vbsme_pkg;

  // Block size encoding as carried on BlkSize.
  typedef enum logic [1:0] {
    BLK_4X4   = 2'b00,
    BLK_8X8   = 2'b01,
    BLK_16X16 = 2'b10,
    BLK_ILL   = 2'b11
  } blk_size_t;

  // Search controller states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_DRAIN = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Block edge in pixels; the illegal code never reaches the datapath.
  function automatic logic [4:0] blk_edge(input blk_size_t b);
    case (b)
      BLK_4X4:   blk_edge = 5'd4;
      BLK_8X8:   blk_edge = 5'd8;
      BLK_16X16: blk_edge = 5'd16;
      default:   blk_edge = 5'd4;
    endcase
  endfunction

endpackage

// File: rtl/sad_pos_fifo.sv
// Position FIFO: holds {X,Y} of candidates issued but not yet returned.
module sad_pos_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_n;

  assign dout = mem[rptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // Storage array; contents need no reset since empty/full gate their use.
  always_ff @(posedge Clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/sad_search_controller.sv
// Full-search SAD sequencer: issues candidate positions in raster order,
// pairs returned SADs with their positions and keeps the running minimum.
module sad_search_controller
  import vbsme_pkg::*;
#(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int SAD_W   = 16,
  parameter int MAX_OUT = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       Start,
  input  logic [1:0]                 BlkSize,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Err,
  output logic                       CandValid,
  input  logic                       CandReady,
  output logic [$clog2(FRAME_W)-1:0] CandX,
  output logic [$clog2(FRAME_H)-1:0] CandY,
  input  logic                       SadValid,
  input  logic [SAD_W-1:0]           SadIn,
  output logic [$clog2(FRAME_W)-1:0] BestX,
  output logic [$clog2(FRAME_H)-1:0] BestY,
  output logic [SAD_W-1:0]           BestSad
);

  localparam int XW = $clog2(FRAME_W);
  localparam int YW = $clog2(FRAME_H);
  localparam int CW = $clog2(MAX_OUT + 1);

  state_t         state;
  state_t         state_n;
  blk_size_t      blk_q;
  logic [4:0]     b_edge;
  logic [XW-1:0]  x_max;
  logic [YW-1:0]  y_max;
  logic           x_last;
  logic           y_last;
  logic           start_ok;
  logic           start_bad;
  logic           sad_bad;
  logic           hs;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_cnt;
  logic [XW+YW-1:0] head;
  logic [XW-1:0]  head_x;
  logic [YW-1:0]  head_y;

  // Last legal top-left coordinate for the latched block size.
  assign b_edge = blk_edge(blk_q);
  assign x_max  = XW'(FRAME_W - int'(b_edge));
  assign y_max  = YW'(FRAME_H - int'(b_edge));
  assign x_last = (CandX == x_max);
  assign y_last = (CandY == y_max);

  assign start_ok  = (state == S_IDLE) && Start && (BlkSize != 2'b11);
  assign start_bad = (state == S_IDLE) && Start && (BlkSize == 2'b11);

  // Results are only meaningful when a position is outstanding.
  assign pop     = SadValid && (state != S_IDLE) && !fifo_empty;
  assign sad_bad = SadValid && ((state == S_IDLE) || fifo_empty);

  // Offer decoded from state and the registered full flag.
  assign CandValid = (state == S_ISSUE) && !fifo_full;
  assign hs        = CandValid && CandReady;

  assign {head_x, head_y} = head;

  sad_pos_fifo #(
    .DW    (XW + YW),
    .DEPTH (MAX_OUT)
  ) u_fifo (
    .Clk   (Clk),
    .Rst   (Rst),
    .push  (hs),
    .pop   (pop),
    .din   ({CandX, CandY}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_ok) state_n = S_ISSUE;
      S_ISSUE: if (hs && x_last && y_last) state_n = S_DRAIN;
      S_DRAIN: if (fifo_empty || (pop && fifo_cnt == CW'(1))) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Err   <= 1'b0;
    end else begin
      state <= state_n;
      Busy  <= (state_n != S_IDLE);
      Done  <= (state_n == S_DONE);
      Err   <= start_bad || sad_bad;
    end
  end

  // Raster position counters; they only move on an accepted handshake.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      blk_q <= BLK_4X4;
      CandX <= '0;
      CandY <= '0;
    end else if (start_ok) begin
      blk_q <= blk_size_t'(BlkSize);
      CandX <= '0;
      CandY <= '0;
    end else if (hs) begin
      if (x_last) begin
        CandX <= '0;
        CandY <= y_last ? '0 : CandY + 1'b1;
      end else begin
        CandX <= CandX + 1'b1;
      end
    end
  end

  // Minimum tracker; strict compare keeps the earliest raster position on ties.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      BestSad <= '1;
      BestX   <= '0;
      BestY   <= '0;
    end else if (start_ok) begin
      BestSad <= '1;
      BestX   <= '0;
      BestY   <= '0;
    end else if (pop && (SadIn < BestSad)) begin
      BestSad <= SadIn;
      BestX   <= head_x;
      BestY   <= head_y;
    end
  end

endmodule

// File: tb/tb_sad_search_controller.sv
// Scoreboard bench for sad_search_controller with a 16x16 search window.
module tb_sad_search_controller;

  localparam int FW = 16;
  localparam int FH = 16;
  localparam int SW = 16;
  localparam int MO = 4;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Start = 1'b0;
  logic [1:0]    BlkSize = 2'b00;
  logic          Busy, Done, Err, CandValid;
  logic          CandReady = 1'b0;
  logic [3:0]    CandX, CandY, BestX, BestY;
  logic          SadValid = 1'b0;
  logic [SW-1:0] SadIn = '0;
  logic [SW-1:0] BestSad;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  sad_search_controller #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .SAD_W   (SW),
    .MAX_OUT (MO)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .BlkSize   (BlkSize),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err),
    .CandValid (CandValid),
    .CandReady (CandReady),
    .CandX     (CandX),
    .CandY     (CandY),
    .SadValid  (SadValid),
    .SadIn     (SadIn),
    .BestX     (BestX),
    .BestY     (BestY),
    .BestSad   (BestSad)
  );

  // Reference SAD unit content per pattern.
  function automatic logic [SW-1:0] sad_of(input int pat, input int x, input int y);
    case (pat)
      1:       return (x == 3 && y == 5) ? 16'd7 : 16'd100;
      2:       return 16'd50;
      3:       return ((x == 2 && y == 1) || (x == 10 && y == 4)) ? 16'd9
                      : 16'(20 + ((x * 7 + y * 3) % 50));
      default: return 16'd100;
    endcase
  endfunction

  // Runs one search: expected raster positions are queued up front and popped
  // on every observed handshake; returned SADs follow issue order after `delay`.
  task automatic drive_search(input logic [1:0] blk, input int ready_pct,
                              input int delay, input int pat, input int abort_at,
                              output int hs_cnt, output int done_cnt,
                              output int cyc_used, output int err_cnt);
    int exp_x[$], exp_y[$];
    int px[$], py[$], pdue[$];
    int b, sx, sy, ex, ey, last_sad_c;
    bit stalled, rdy;
    b = (blk == 2'b00) ? 4 : (blk == 2'b01) ? 8 : 16;
    for (int y = 0; y <= FH - b; y++)
      for (int x = 0; x <= FW - b; x++) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
      end
    hs_cnt = 0; done_cnt = 0; cyc_used = -1; err_cnt = 0;
    stalled = 0; sx = 0; sy = 0; last_sad_c = -10;
    Start = 1'b1; BlkSize = blk;
    @(posedge Clk); #1;
    Start = 1'b0;
    checks++;
    if (CandValid !== 1'b1) begin
      failures++;
      $display("FAIL cand_valid_cycle1 got=%b exp=1", CandValid);
    end
    for (int c = 0; c < 4000; c++) begin
      if (Err) err_cnt++;
      if (Done) begin
        done_cnt++;
        cyc_used = c;
        CandReady = 1'b0; SadValid = 1'b0;
        checks++;
        if (last_sad_c != c - 1) begin
          failures++;
          $display("FAIL done_latency last_result_cycle=%0d done_cycle=%0d exp_gap=1", last_sad_c, c);
        end
        break;
      end
      if (stalled) begin
        checks++;
        if (CandX !== 4'(sx) || CandY !== 4'(sy)) begin
          failures++;
          $display("FAIL stall_stable got=(%0d,%0d) exp=(%0d,%0d)", CandX, CandY, sx, sy);
        end
      end
      rdy = (int'($urandom_range(99)) < ready_pct);
      CandReady = rdy;
      if (CandValid && rdy) begin
        hs_cnt++;
        checks++;
        if (exp_x.size() == 0) begin
          failures++;
          $display("FAIL extra_handshake got=(%0d,%0d) exp=none", CandX, CandY);
        end else begin
          ex = exp_x.pop_front(); ey = exp_y.pop_front();
          if (CandX !== 4'(ex) || CandY !== 4'(ey)) begin
            failures++;
            $display("FAIL cand_pos got=(%0d,%0d) exp=(%0d,%0d)", CandX, CandY, ex, ey);
          end
        end
        px.push_back(int'(CandX)); py.push_back(int'(CandY)); pdue.push_back(c + delay);
      end
      stalled = CandValid && !rdy;
      sx = int'(CandX); sy = int'(CandY);
      if (pdue.size() > 0 && pdue[0] <= c) begin
        SadValid = 1'b1;
        SadIn = sad_of(pat, px[0], py[0]);
        void'(px.pop_front()); void'(py.pop_front()); void'(pdue.pop_front());
        last_sad_c = c;
      end else begin
        SadValid = 1'b0;
      end
      @(posedge Clk); #1;
      if (abort_at > 0 && hs_cnt == abort_at) begin
        CandReady = 1'b0; SadValid = 1'b0;
        Rst = 1'b0;
        #1;
        return;
      end
    end
    CandReady = 1'b0; SadValid = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL search_timeout got_done=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({Busy, Done, Err, CandValid} !== 4'b0000 || CandX !== 4'd0 || CandY !== 4'd0 ||
        BestX !== 4'd0 || BestY !== 4'd0 || BestSad !== 16'hFFFF) begin
      failures++;
      $display("FAIL reset_values got busy=%b done=%b err=%b cv=%b cand=(%0d,%0d) best=(%0d,%0d,%0h) exp all zero, sad=ffff",
               Busy, Done, Err, CandValid, CandX, CandY, BestX, BestY, BestSad);
    end
    Rst = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic check_result(input string name, input int hs, input int exp_hs,
                              input int done_cnt, input int err_cnt,
                              input int bx, input int by, input int bs);
    checks++;
    if (hs != exp_hs) begin
      failures++;
      $display("FAIL %s_handshakes got=%0d exp=%0d", name, hs, exp_hs);
    end
    checks++;
    if (BestX !== 4'(bx) || BestY !== 4'(by) || BestSad !== 16'(bs)) begin
      failures++;
      $display("FAIL %s_best got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", name, BestX, BestY, BestSad, bx, by, bs);
    end
    checks++;
    if (done_cnt != 1 || err_cnt != 0) begin
      failures++;
      $display("FAIL %s_done_err got done=%0d err=%0d exp done=1 err=0", name, done_cnt, err_cnt);
    end
    @(posedge Clk); #1;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse got done=%b busy=%b exp 0 0", name, Done, Busy);
    end
  endtask

  task automatic test_basic();
    int hs, dn, cyc, er;
    drive_search(2'b01, 100, 1, 1, 0, hs, dn, cyc, er);
    check_result("basic", hs, 81, dn, er, 3, 5, 7);
    checks++;
    if (cyc != 82) begin
      failures++;
      $display("FAIL basic_throughput got_cycles=%0d exp=82", cyc);
    end
  endtask

  task automatic test_single();
    int hs, dn, cyc, er;
    drive_search(2'b10, 100, 1, 2, 0, hs, dn, cyc, er);
    check_result("single", hs, 1, dn, er, 0, 0, 50);
  endtask

  task automatic test_tie_stall();
    int hs, dn, cyc, er;
    drive_search(2'b00, 50, 3, 3, 0, hs, dn, cyc, er);
    check_result("tie", hs, 169, dn, er, 2, 1, 9);
  endtask

  task automatic test_errors();
    Start = 1'b1; BlkSize = 2'b11;
    @(posedge Clk); #1;
    Start = 1'b0; BlkSize = 2'b00;
    checks++;
    if (Err !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL illegal_blk got err=%b busy=%b exp 1 0", Err, Busy);
    end
    @(posedge Clk); #1;
    checks++;
    if (Err !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL illegal_blk_once got err=%b busy=%b exp 0 0", Err, Busy);
    end
    SadValid = 1'b1; SadIn = 16'd1;
    @(posedge Clk); #1;
    SadValid = 1'b0;
    checks++;
    if (Err !== 1'b1 || BestX !== 4'd2 || BestY !== 4'd1 || BestSad !== 16'd9) begin
      failures++;
      $display("FAIL idle_sad got err=%b best=(%0d,%0d,%0d) exp err=1 best=(2,1,9)", Err, BestX, BestY, BestSad);
    end
    @(posedge Clk); #1;
    checks++;
    if (Err !== 1'b0) begin
      failures++;
      $display("FAIL idle_sad_once got err=%b exp=0", Err);
    end
  endtask

  task automatic test_backpressure();
    int hs;
    hs = 0;
    Start = 1'b1; BlkSize = 2'b01;
    @(posedge Clk); #1;
    Start = 1'b0;
    CandReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (CandValid) hs++;
      @(posedge Clk); #1;
    end
    checks++;
    if (hs != MO || CandValid !== 1'b0) begin
      failures++;
      $display("FAIL fifo_full got hs=%0d cv=%b exp hs=%0d cv=0", hs, CandValid, MO);
    end
    SadValid = 1'b1; SadIn = 16'd5;
    @(posedge Clk); #1;
    SadValid = 1'b0;
    checks++;
    if (CandValid !== 1'b1 || BestSad !== 16'd5 || BestX !== 4'd0 || BestY !== 4'd0) begin
      failures++;
      $display("FAIL fifo_resume got cv=%b best=(%0d,%0d,%0d) exp cv=1 best=(0,0,5)", CandValid, BestX, BestY, BestSad);
    end
    CandReady = 1'b0;
    Rst = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_abort();
    int hs, dn, cyc, er;
    drive_search(2'b01, 100, 1, 1, 20, hs, dn, cyc, er);
    checks++;
    if (hs != 20 || dn != 0 || {Busy, Done, Err, CandValid} !== 4'b0000 || CandX !== 4'd0 ||
        CandY !== 4'd0 || BestX !== 4'd0 || BestY !== 4'd0 || BestSad !== 16'hFFFF) begin
      failures++;
      $display("FAIL abort_reset got hs=%0d done=%0d busy=%b done_o=%b err=%b cv=%b cand=(%0d,%0d) best=(%0d,%0d,%0h) exp reset values",
               hs, dn, Busy, Done, Err, CandValid, CandX, CandY, BestX, BestY, BestSad);
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    drive_search(2'b01, 100, 1, 1, 0, hs, dn, cyc, er);
    check_result("after_abort", hs, 81, dn, er, 3, 5, 7);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_tie_stall();
    test_errors();
    test_backpressure();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
